// File: rtl/neuron_pkg.sv
// Shared FSM state encoding, activation-mode encodings and saturating arithmetic
// for the neuron MAC datapath.
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_BIAS,
        ST_ACT,
        ST_OUT
    } state_t;

    localparam logic ACT_LINEAR = 1'b0;
    localparam logic ACT_RELU   = 1'b1;

    // Adds two sign-extended operands and clamps the sum to a signed w-bit range (w <= 64).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi[63:0];
        end else if (s < lo) begin
            return lo[63:0];
        end else begin
            return s[63:0];
        end
    endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Banked weight store: LANES banks of DEPTH words, one write port and one
// registered read port that returns a whole row (one word per bank).
module neuron_wmem
    import neuron_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BANK_W = 2
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [BANK_W-1:0]         wr_bank,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [LANES*DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [LANES][DEPTH];

    // Contents are deliberately not reset so weights survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        if (rd_en) begin
            for (int k = 0; k < LANES; k++) begin
                rd_data[k*DATA_W +: DATA_W] <= mem[k][rd_addr];
            end
        end
    end

endmodule

// File: rtl/neuron_mac_gen.sv
// One neuron: streams LANES inputs per beat against stored weights, accumulates
// with saturation, adds a bias, applies linear/ReLU and hands the result out.
module neuron_mac_gen
    import neuron_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int NUM_WEIGHT = 32,
    parameter int LANES      = 4,
    parameter int LAYER_ID   = 1,
    parameter int NEURON_ID  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              cfg_layer,
    input  logic [31:0]              cfg_neuron,
    input  logic                     wt_valid,
    input  logic [DATA_W-1:0]        wt_data,
    input  logic                     bias_valid,
    input  logic [DATA_W-1:0]        bias_data,
    input  logic                     act_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     wt_err
);

    localparam int DEPTH  = NUM_WEIGHT / LANES;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;

    localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_nx;

    logic                     ready_en;
    logic                     accept;
    logic                     last_beat;
    logic                     to_idle;
    logic                     sel;
    logic                     wt_wr;
    logic                     bias_wr;
    logic                     cfg_drop;
    logic                     mode_reg;
    logic [BANK_W-1:0]        wr_bank;
    logic [ADDR_W-1:0]        wr_addr;
    logic [ADDR_W-1:0]        rd_ptr;
    logic signed [DATA_W-1:0] bias_reg;
    logic signed [ACC_W-1:0]  acc;

    logic [LANES*DATA_W-1:0]  data_p0;
    logic [LANES*DATA_W-1:0]  wrow_p0;
    logic                     vld_p0;
    logic signed [PROD_W-1:0] lane_x [LANES];
    logic signed [PROD_W-1:0] lane_w [LANES];
    logic signed [PROD_W-1:0] prod_p1 [LANES];
    logic                     vld_p1;
    logic signed [SUM_W-1:0]  lane_sum;
    logic                     vld_p2;

    // Arithmetic shift back to DATA_W, clamp, then optional rectification.
    function automatic logic signed [DATA_W-1:0] activate(
        input logic signed [ACC_W-1:0] a,
        input logic                    mode
    );
        logic signed [ACC_W-1:0]  q;
        logic signed [DATA_W-1:0] r;
        q = a >>> FRAC_W;
        if (q > Q_MAX) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (q < Q_MIN) begin
            r = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = q[DATA_W-1:0];
        end
        if (mode == ACT_RELU && r[DATA_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

    assign sel       = (cfg_layer == LAYER_ID) && (cfg_neuron == NEURON_ID);
    assign wt_wr     = sel && wt_valid && (state == ST_IDLE);
    assign bias_wr   = sel && bias_valid && (state == ST_IDLE);
    assign cfg_drop  = sel && (wt_valid || bias_valid) && (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (rd_ptr == ADDR_W'(DEPTH - 1));
    assign to_idle   = (state == ST_OUT) && out_valid && out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (ready_en && (state == ST_IDLE || state == ST_ACCUM)) begin
            in_ready = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = last_beat ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (accept && last_beat) state_nx = ST_DRAIN;
            ST_DRAIN: if (!(vld_p0 || vld_p1 || vld_p2)) state_nx = ST_BIAS;
            ST_BIAS:  state_nx = ST_ACT;
            ST_ACT:   state_nx = ST_OUT;
            ST_OUT:   if (out_valid && out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    neuron_wmem #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_wmem (
        .clk     (clk),
        .wr_en   (wt_wr),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wt_data),
        .rd_en   (accept),
        .rd_addr (rd_ptr),
        .rd_data (wrow_p0)
    );

    // p0 -> p1: per-lane signed products of the registered beat and weight row
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_x[k] = PROD_W'($signed(data_p0[k*DATA_W +: DATA_W]));
            lane_w[k] = PROD_W'($signed(wrow_p0[k*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p0 <= in_data;
        end
        for (int k = 0; k < LANES; k++) begin
            prod_p1[k] <= lane_x[k] * lane_w[k];
        end
    end

    // p1 -> p2: exact lane sum folded into the saturating accumulator
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + SUM_W'(prod_p1[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en  <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            mode_reg  <= ACT_LINEAR;
            wr_bank   <= '0;
            wr_addr   <= '0;
            rd_ptr    <= '0;
            bias_reg  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            wt_err    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            vld_p0   <= accept;
            vld_p1   <= vld_p0;
            vld_p2   <= vld_p1;

            if (accept && state == ST_IDLE) begin
                mode_reg <= act_mode;
            end

            if (wt_wr) begin
                if (wr_bank == BANK_W'(LANES - 1)) begin
                    wr_bank <= '0;
                    wr_addr <= (wr_addr == ADDR_W'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
                end else begin
                    wr_bank <= wr_bank + 1'b1;
                end
            end
            if (bias_wr) begin
                bias_reg <= bias_data;
            end
            if (cfg_drop) begin
                wt_err <= 1'b1;
            end

            if (accept) begin
                rd_ptr <= last_beat ? '0 : rd_ptr + 1'b1;
            end

            // The drain wait guarantees lane sums and the bias add never coincide.
            if (to_idle) begin
                rd_ptr <= '0;
                acc    <= '0;
            end else if (vld_p1) begin
                acc <= ACC_W'(sat_add(64'(acc), 64'(lane_sum), ACC_W));
            end else if (state == ST_BIAS) begin
                acc <= ACC_W'(sat_add(64'(acc), 64'(bias_reg) <<< FRAC_W, ACC_W));
            end

            if (state == ST_ACT) begin
                out_valid <= 1'b1;
                out_data  <= activate(acc, mode_reg);
            end else if (to_idle) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_gen.sv
// Bench for neuron_mac_gen: table of uniform-operand inferences, a reference
// model for random operands, and hand-written sequences for handshake/reset cases.
module tb_neuron_mac_gen;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_layer;
    logic [31:0] cfg_neuron;
    logic        wt_valid;
    logic [15:0] wt_data;
    logic        bias_valid;
    logic [15:0] bias_data;
    logic        act_mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        wt_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wv [32];
    logic [15:0] iv [32];
    logic [15:0] sb [$];

    typedef struct {
        string       name;
        logic [15:0] wt;
        logic [15:0] din;
        logic [15:0] bias;
        logic        mode;
        logic [15:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs [6];

    localparam longint A_MAX = 64'sd2147483647;
    localparam longint A_MIN = -64'sd2147483648;

    neuron_mac_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_layer  (cfg_layer),
        .cfg_neuron (cfg_neuron),
        .wt_valid   (wt_valid),
        .wt_data    (wt_data),
        .bias_valid (bias_valid),
        .bias_data  (bias_data),
        .act_mode   (act_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .wt_err     (wt_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > A_MAX) return A_MAX;
        if (v < A_MIN) return A_MIN;
        return v;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] bias, input logic mode);
        longint acc;
        longint s;
        longint q;
        acc = 0;
        for (int b = 0; b < 8; b++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                s += longint'($signed(wv[b*4+k])) * longint'($signed(iv[b*4+k]));
            end
            acc = sat32(acc + s);
        end
        acc = sat32(acc + longint'($signed(bias)) * 256);
        q = acc >>> 8;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (mode && q < 0) q = 0;
        return 16'(q);
    endfunction

    function automatic logic [63:0] pack_beat(input int b);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*16 +: 16] = iv[b*4+k];
        end
        return r;
    endfunction

    task automatic load_weights();
        for (int i = 0; i < 32; i++) begin
            wt_valid = 1'b1;
            wt_data  = wv[i];
            @(posedge clk); #1;
        end
        wt_valid = 1'b0;
    endtask

    task automatic load_bias(input logic [15:0] b);
        bias_valid = 1'b1;
        bias_data  = b;
        @(posedge clk); #1;
        bias_valid = 1'b0;
    endtask

    // Streams 8 back-to-back beats, flips act_mode after the first beat, optionally
    // injects a selected weight write mid-stream and optionally stalls out_ready.
    task automatic run_inf(input logic mode, input logic [15:0] exp, input string name,
                           input int hold, input logic inject);
        int          n;
        logic [15:0] d0;
        logic [15:0] e;
        sb.push_back(exp);
        out_ready = (hold == 0);
        act_mode  = mode;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            in_data  = pack_beat(b);
            if (inject && b == 2) begin
                wt_valid = 1'b1;
                wt_data  = 16'h0000;
            end
            @(posedge clk); #1;
            wt_valid = 1'b0;
            if (b == 0) act_mode = ~mode;
        end
        in_valid = 1'b0;
        n = 0;
        while (n < 30 && !out_valid) begin
            @(posedge clk); #1;
            n++;
        end
        chk({"lat_", name}, 32'(n), 32'd6);
        if (sb.size() == 0) begin
            chk({"sb_empty_", name}, 32'(out_data), 32'hdead);
        end else begin
            e = sb.pop_front();
            chk({"data_", name}, 32'(out_data), 32'(e));
        end
        d0 = out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_%s", h, name), {13'd0, out_valid, in_ready, 1'b0, out_data},
                {13'd0, 1'b1, 1'b0, 1'b0, d0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({"ret_idle_", name}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        logic [15:0] rb;
        logic [15:0] ex;

        rst        = 1'b0;
        cfg_layer  = 32'd1;
        cfg_neuron = 32'd0;
        wt_valid   = 1'b0;
        wt_data    = '0;
        bias_valid = 1'b0;
        bias_data  = '0;
        act_mode   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;

        vecs[0] = '{"half_x_one",  16'h0100, 16'h0080, 16'h0000, 1'b0, 16'h1000, 10};
        vecs[1] = '{"neg_relu",    16'h0100, 16'hFF00, 16'h0200, 1'b1, 16'h0000, 0};
        vecs[2] = '{"neg_linear",  16'h0100, 16'hFF00, 16'h0200, 1'b0, 16'hE200, 0};
        vecs[3] = '{"pos_sat",     16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 0};
        vecs[4] = '{"neg_sat",     16'h7FFF, 16'h8000, 16'h0000, 1'b0, 16'h8000, 0};
        vecs[5] = '{"mixed",       16'h0080, 16'h0300, 16'h0100, 1'b0, 16'h3100, 0};

        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_wt_err",    32'(wt_err),    32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        foreach (vecs[v]) begin
            for (int i = 0; i < 32; i++) begin
                wv[i] = vecs[v].wt;
                iv[i] = vecs[v].din;
            end
            load_weights();
            load_bias(vecs[v].bias);
            run_inf(vecs[v].mode, vecs[v].exp, vecs[v].name, vecs[v].hold, 1'b0);
        end

        // Writes addressed to another neuron must be ignored silently.
        cfg_neuron = 32'd5;
        for (int i = 0; i < 32; i++) begin
            wt_valid = 1'b1;
            wt_data  = 16'h7FFF;
            @(posedge clk); #1;
        end
        wt_valid   = 1'b0;
        load_bias(16'h7FFF);
        cfg_neuron = 32'd0;
        run_inf(1'b0, 16'h3100, "unselected", 0, 1'b0);
        chk("wt_err_unsel", 32'(wt_err), 32'd0);

        // Selected weight write during ACCUM is dropped and flagged.
        run_inf(1'b0, 16'h3100, "drop_wr", 0, 1'b1);
        chk("wt_err_set", 32'(wt_err), 32'd1);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 32; i++) begin
                wv[i] = 16'($urandom_range(0, 511)) - 16'd256;
                iv[i] = 16'($urandom_range(0, 1023)) - 16'd512;
            end
            rb = 16'($urandom_range(0, 2047)) - 16'd1024;
            ex = model(rb, r[0]);
            load_weights();
            load_bias(rb);
            run_inf(r[0], ex, $sformatf("rand%0d", r), 0, 1'b0);
        end

        // Reset after three beats aborts the inference; weights survive, bias does not.
        for (int i = 0; i < 32; i++) begin
            wv[i] = 16'h0100;
            iv[i] = 16'h0080;
        end
        load_weights();
        load_bias(16'h0300);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = pack_beat(b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("abort_in_ready",  32'(in_ready),  32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_data",  32'(out_data),  32'd0);
        chk("abort_wt_err",    32'(wt_err),    32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst  = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_out", 32'(seen), 32'd0);
        run_inf(1'b0, 16'h1000, "post_rst", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_mac_gen.md
NEURON_MAC_GEN -- requirements
Module: neuron_mac_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of inputs, weights, bias and output, signed Q format.
REQ-002 SHALL have parameter FRAC_W, default 8: fractional bits of the DATA_W format.
REQ-003 SHALL have parameter NUM_WEIGHT, default 32: weights per neuron; must be a multiple of LANES.
REQ-004 SHALL have parameter LANES, default 4: input words consumed per beat.
REQ-005 SHALL have parameters LAYER_ID, default 1, and NEURON_ID, default 0: configuration address of this instance.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: cfg_layer  in  32  target layer; cfg_neuron  in  32  target neuron.
REQ-008 SHALL have ports: wt_valid  in  1  weight write strobe; wt_data  in  DATA_W  weight value.
REQ-009 SHALL have ports: bias_valid  in  1  bias write strobe; bias_data  in  DATA_W  bias value.
REQ-010 SHALL have ports: act_mode  in  1  0=linear, 1=ReLU, sampled at first beat.
REQ-011 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  LANES*DATA_W, lane k in bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_W  activated result.
REQ-013 SHALL have port: wt_err  out  1  sticky flag for a dropped weight or bias write.

Function
REQ-014 A config write is selected only when cfg_layer==LAYER_ID and cfg_neuron==NEURON_ID.
REQ-015 A selected wt_valid in IDLE writes weight i to bank i%LANES, address i/LANES; i increments and wraps from NUM_WEIGHT-1 to 0.
REQ-016 A selected bias_valid in IDLE loads bias_reg.
REQ-017 A selected weight or bias write outside IDLE is dropped and sets wt_err; wt_err clears only on reset.
REQ-018 FSM states: IDLE, ACCUM, DRAIN, BIAS, ACT, OUT.
REQ-019 Transitions: IDLE->ACCUM on the first accepted beat; ACCUM->DRAIN after beat NUM_WEIGHT/LANES; DRAIN->BIAS when the pipeline is empty; BIAS->ACT and ACT->OUT after one cycle each; OUT->IDLE when out_valid&&out_ready.
REQ-020 in_ready=1 in IDLE and ACCUM, 0 otherwise; a beat transfers when in_valid&&in_ready.
REQ-021 Beat pipeline: cycle t accept; t+1 weight row read and input registered; t+2 LANES signed DATA_WxDATA_W products registered; t+3 lane sum added to acc.
REQ-022 The accumulator is 2*DATA_W signed; every add saturates to the signed 2*DATA_W maximum or minimum on overflow.
REQ-023 BIAS adds sign-extended bias_reg<<FRAC_W to acc, with saturation.
REQ-024 ACT: q=acc>>>FRAC_W saturated to signed DATA_W; linear gives q; ReLU gives max(q,0).
REQ-025 out_data and out_valid hold stable in OUT until out_ready; a result is never dropped.
REQ-026 Latency from the last beat accepted to out_valid is 6 cycles with no input gaps.
REQ-027 The read pointer and acc clear on the transition to IDLE; weights and bias_reg persist between inferences.

Reset
REQ-028 rst low asynchronously forces IDLE, acc=0, bias_reg=0, weight pointer=0, read pointer=0, out_valid=0, out_data=0, wt_err=0, in_ready=0.
REQ-029 Weight memory contents are not reset; reset during ACCUM aborts the inference and produces no out_valid.

Structure
REQ-030 A shared package neuron_pkg SHALL hold the FSM state enum, the act_mode encodings and the saturating-add function.
REQ-031 Weight storage SHALL be one sub-module, neuron_wmem: LANES banks of NUM_WEIGHT/LANES words, 1 write and 1 registered read port.

Verification
REQ-032 Load weights all 0x0100 (1.0) and bias 0, stream 8 beats of inputs all 0x0080 (0.5) -> out_data=0x1000 (16.0) 6 cycles after the last beat.
REQ-033 Same weights, inputs all 0xFF00 (-1.0), bias 0x0200, ReLU -> out_data=0x0000; linear -> 0xE200 (-30.0).
REQ-034 Weights 0x7FFF, inputs 0x7FFF -> acc saturates positive; out_data=0x7FFF.
REQ-035 Hold out_ready=0 for 10 cycles at OUT -> out_valid and out_data stable and in_ready=0 throughout; the handshake then returns the FSM to IDLE.
REQ-036 Selected wt_valid during ACCUM -> weight not written and wt_err=1; rst pulsed after beat 3 -> no out_valid and a following inference is correct.
